// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a NAND-built 4:1 mux. It steps s1:s0 through the enabled channels,
// lets the mux settle, samples w, and publishes all four samples as one word.
module mux_scan_sequencer #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       cont,
  input  logic       w,
  output logic       s0,
  output logic       s1,
  output logic [3:0] data,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [3:0] mask_q;
  logic [3:0] shadow_q;
  logic [3:0] data_q;
  logic [1:0] sel_q;
  logic       valid_q;
  logic       busy_q;

  logic [2:0] first_hit;
  logic [2:0] next_hit;
  logic       launch;

  // Returns {found, index} of the lowest set bit of m at or above position 'from'.
  function automatic logic [2:0] next_set(input logic [3:0] m, input logic [2:0] from);
    next_set = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (3'(i) >= from && m[i]) next_set = {1'b1, 2'(i)};
    end
  endfunction

  assign first_hit = next_set(mask, 3'd0);
  assign next_hit  = next_set(mask_q, {1'b0, sel_q} + 3'd1);

  // A new scan starts from IDLE on start, or straight out of DONE in continuous mode.
  assign launch = (state_q == ST_IDLE && start) || (state_q == ST_DONE && cont);

  // NOTE: all state is updated with non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      // NOTE: the shadow word is reset too, so an aborted scan can never leak
      // stale channel samples into a later data word.
      shadow_q <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: ;
        ST_SETTLE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          shadow_q[sel_q] <= w;
          if (next_hit[2]) begin
            sel_q   <= next_hit[1:0];
            cnt_q   <= '0;
            state_q <= ST_SETTLE;
          end else begin
            sel_q   <= 2'b00;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          data_q  <= shadow_q & mask_q;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // Later assignments win: a launch overrides the DONE -> IDLE return above.
      if (launch) begin
        mask_q   <= mask;
        shadow_q <= '0;
        busy_q   <= 1'b1;
        cnt_q    <= '0;
        if (first_hit[2]) begin
          sel_q   <= first_hit[1:0];
          state_q <= ST_SETTLE;
        end else begin
          sel_q   <= 2'b00;
          state_q <= ST_DONE;
        end
      end
    end
  end

  assign s0    = sel_q[0];
  assign s1    = sel_q[1];
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: a behavioural 4:1 mux feeds w, and a
// scan-level model (enabled-channel list, latency formula, mask & inputs) predicts results.
module tb_mux_scan_sequencer;

  localparam int SETTLE = 4;
  localparam int MAXC   = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] mask;
  logic       cont;
  logic       w;
  logic       s0, s1, valid, busy;
  logic [3:0] data;
  logic [3:0] din;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] obs_sel   [MAXC];
  logic       obs_valid [MAXC];
  logic       obs_busy  [MAXC];
  logic [3:0] obs_data  [MAXC];

  always #5 clk = ~clk;

  // Mux inputs a..d are din[0..3].
  assign w = din[{s1, s0}];

  mux_scan_sequencer #(.SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mask  (mask),
    .cont  (cont),
    .w     (w),
    .s0    (s0),
    .s1    (s1),
    .data  (data),
    .valid (valid),
    .busy  (busy)
  );

  // Model: enabled channels are visited in ascending order, SETTLE+1 cycles each.
  function automatic logic [1:0] model_sel(input logic [3:0] m, input int n);
    int chans[$];
    for (int i = 0; i < 4; i++) if (m[i]) chans.push_back(i);
    if (n / (SETTLE + 1) < chans.size()) return 2'(chans[n / (SETTLE + 1)]);
    return 2'b00;
  endfunction

  function automatic int model_latency(input logic [3:0] m);
    return $countones(m) * (SETTLE + 1) + 1;
  endfunction

  // Starts a scan and logs outputs at the negedge after each of the next ncyc edges.
  // Index n holds what is visible after the (n)th edge following the start edge.
  task automatic record_scan(input logic [3:0] m, input logic [3:0] inputs,
                             input int ncyc, input int disturb);
    din = inputs;
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      obs_sel[n]   = {s1, s0};
      obs_valid[n] = valid;
      obs_busy[n]  = busy;
      obs_data[n]  = data;
      start = (n == disturb);
      if (n == disturb) mask = 4'b0001;
    end
    start = 1'b0;
  endtask

  task automatic scan_and_compare(input string name, input logic [3:0] m,
                                  input logic [3:0] inputs, input int disturb,
                                  output int first_v);
    int lat, ncyc, bad_sel, bad_busy, bad_valid, first_bad;
    logic [1:0] exp_sel;
    lat  = model_latency(m);
    ncyc = lat + 4;
    record_scan(m, inputs, ncyc, disturb);
    bad_sel = 0; bad_busy = 0; bad_valid = 0; first_bad = -1; first_v = -1;
    for (int n = 0; n < ncyc; n++) begin
      exp_sel = model_sel(m, n);
      if (obs_sel[n] !== exp_sel) begin
        if (first_bad < 0) first_bad = n;
        bad_sel++;
      end
      if (obs_busy[n] !== (n < lat)) bad_busy++;
      if (obs_valid[n] !== (n == lat)) bad_valid++;
      if (obs_valid[n] === 1'b1 && first_v < 0) first_v = n;
    end
    n_cmp++;
    if (bad_sel != 0) begin
      n_err++;
      $display("FAIL %s sel_trace: %0d bad cycles, first at %0d got %b want %b", name,
               bad_sel, first_bad, obs_sel[first_bad], model_sel(m, first_bad));
    end
    n_cmp++;
    if (bad_busy != 0) begin
      n_err++;
      $display("FAIL %s busy_trace: %0d bad cycles (want high for %0d cycles)", name,
               bad_busy, lat);
    end
    n_cmp++;
    if (bad_valid != 0) begin
      n_err++;
      $display("FAIL %s valid_trace: first valid at %0d, want single pulse at %0d", name,
               first_v, lat);
    end
    n_cmp++;
    if (obs_data[lat] !== (m & inputs)) begin
      n_err++;
      $display("FAIL %s data: got %b want %b", name, obs_data[lat], m & inputs);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mask = 4'b0000; cont = 1'b0; din = 4'b0000;
    #12;
    n_cmp++;
    if ({s1, s0, busy, valid, data} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got %b want 00000000", {s1, s0, busy, valid, data});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_scan();
    int fv;
    scan_and_compare("full_scan", 4'b1111, 4'b1101, -1, fv);
    n_cmp++;
    if (fv !== 21) begin
      n_err++;
      $display("FAIL full_scan latency: got %0d want 21", fv);
    end
  endtask

  task automatic test_sparse_mask();
    int fv;
    scan_and_compare("sparse_mask", 4'b1010, 4'b1011, -1, fv);
    n_cmp++;
    if (fv !== 11) begin
      n_err++;
      $display("FAIL sparse_mask latency: got %0d want 11", fv);
    end
  endtask

  task automatic test_empty_mask();
    int fv;
    scan_and_compare("empty_mask", 4'b0000, 4'b1111, -1, fv);
    n_cmp++;
    if (fv !== 1) begin
      n_err++;
      $display("FAIL empty_mask latency: got %0d want 1", fv);
    end
  endtask

  task automatic test_ignored_start();
    int fv;
    // n=11 falls in the c-channel settle window (cycles 10..13 of the scan).
    scan_and_compare("ignored_start", 4'b1111, 4'b0110, 11, fv);
  endtask

  task automatic test_continuous();
    int  vcyc[3];
    logic [3:0] vdat[3];
    int  nv;
    logic busy42, busy63, busy70;
    logic [3:0] want[3];
    want[0] = 4'b1110; want[1] = 4'b1110; want[2] = 4'b1111;
    nv = 0; busy42 = 1'bx; busy63 = 1'bx; busy70 = 1'bx;
    for (int i = 0; i < 3; i++) begin vcyc[i] = -1; vdat[i] = 4'bxxxx; end
    cont = 1'b1;
    din  = 4'b1110;
    @(negedge clk);
    mask  = 4'b1111;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n <= 70; n++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (nv < 3) begin vcyc[nv] = n; vdat[nv] = data; end
        nv++;
      end
      if (n == 42) busy42 = busy;
      if (n == 63) busy63 = busy;
      if (n == 70) busy70 = busy;
      if (n == 37) din[0] = 1'b1;  // second scan, d-channel settle
      if (n == 50) cont = 1'b0;    // third scan ends the run
    end
    n_cmp++;
    if (nv != 3) begin
      n_err++;
      $display("FAIL cont pulse_count: got %0d want 3", nv);
    end
    n_cmp++;
    if (vcyc[0] != 21) begin
      n_err++;
      $display("FAIL cont first_valid: got %0d want 21", vcyc[0]);
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (vcyc[i] - vcyc[i-1] != 21) begin
        n_err++;
        $display("FAIL cont period%0d: got %0d want 21", i, vcyc[i] - vcyc[i-1]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (vdat[i] !== want[i]) begin
        n_err++;
        $display("FAIL cont data%0d: got %b want %b", i, vdat[i], want[i]);
      end
    end
    n_cmp++;
    if ({busy42, busy63, busy70} !== 3'b100) begin
      n_err++;
      $display("FAIL cont busy@42/63/70: got %b want 100", {busy42, busy63, busy70});
    end
  endtask

  task automatic test_reset_mid_scan();
    int  fv;
    bit  seen;
    int  bad_valid;
    @(negedge clk);
    mask  = 4'b1111;
    start = 1'b1;
    din   = 4'b1111;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if ({s1, s0} === 2'b10) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL reset_mid wait_sel10: select 10 not seen within 30 cycles");
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({s1, s0, busy, valid, data} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid outputs: got %b want 00000000", {s1, s0, busy, valid, data});
    end
    bad_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || data !== 4'b0000) bad_valid++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0) bad_valid++;
    end
    n_cmp++;
    if (bad_valid != 0) begin
      n_err++;
      $display("FAIL reset_mid quiet: %0d cycles with valid/data/busy active, want 0", bad_valid);
    end
    scan_and_compare("after_reset", 4'b1111, 4'b1011, -1, fv);
    n_cmp++;
    if (fv !== 21) begin
      n_err++;
      $display("FAIL after_reset latency: got %0d want 21", fv);
    end
  endtask

  task automatic test_random();
    int fv;
    logic [3:0] m, d;
    for (int i = 0; i < 6; i++) begin
      m = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      scan_and_compare($sformatf("random%0d_m%b_d%b", i, m, d), m, d, -1, fv);
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_empty_mask();
    test_continuous();
    test_ignored_start();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
